// File: rtl/vga_pkg.sv
// vga_pkg: shared types, default 640x480@60 timing and colour-bar palette
// for the VGA scan-out path.
package vga_pkg;

  // One RGB333 pixel: [8:6]=R, [5:3]=G, [2:0]=B.
  typedef logic [8:0] rgb333_t;

  // One FIFO slot: start-of-frame marker plus pixel.
  typedef struct packed {
    logic    sof;
    rgb333_t data;
  } fifo_entry_t;

  // Default 640x480 raster timing.
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int FIFO_DEPTH = 4;

  // Colour bars, index 0 is the leftmost bar.
  localparam int BAR_COUNT = 8;
  localparam rgb333_t [BAR_COUNT-1:0] BAR_COLORS = {
    9'h000, 9'h007, 9'h1C0, 9'h1C7, 9'h038, 9'h03F, 9'h1F8, 9'h1FF
  };

  // Bar number for a horizontal position; clamps to the last bar when the
  // active width is not a multiple of the bar count.
  function automatic logic [2:0] bar_index(input int unsigned hpos,
                                           input int unsigned bar_w);
    int unsigned idx;
    idx = (bar_w == 0) ? 0 : hpos / bar_w;
    return (idx > 7) ? 3'd7 : idx[2:0];
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running raster counters with active, first-pixel,
// vertical-blank and sync-window decode. Decodes are combinational from the
// counters; the consumer registers them so everything stays aligned.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [HW-1:0] hcnt_o,
  output logic [VW-1:0] vcnt_o,
  output logic          active_o,
  output logic          first_o,
  output logic          vblank_o,
  output logic          hsync_o,
  output logic          vsync_o
);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;

  // Advance one pixel; line counter steps when the pixel counter wraps.
  always_comb begin
    hcnt_d = hcnt_q + HW'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == HW'(H_TOTAL - 1)) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == VW'(V_TOTAL - 1)) ? '0 : vcnt_q + VW'(1);
    end
  end

  // Raster position register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt_o   = hcnt_q;
  assign vcnt_o   = vcnt_q;
  assign active_o = (hcnt_q < HW'(H_ACTIVE)) && (vcnt_q < VW'(V_ACTIVE));
  assign first_o  = (hcnt_q == '0) && (vcnt_q == '0);
  assign vblank_o = (vcnt_q >= VW'(V_ACTIVE));
  assign hsync_o  = (hcnt_q >= HW'(H_ACTIVE + H_FP)) &&
                    (hcnt_q <  HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync_o  = (vcnt_q >= VW'(V_ACTIVE + V_FP)) &&
                    (vcnt_q <  VW'(V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: pulls RGB333 pixels from a valid/ready stream through a
// 4-entry FIFO and drives blanked video plus hsync/vsync/blank. Pixel (0,0)
// only accepts a start-of-frame pixel; vertical blanking discards stale
// pixels up to the next start-of-frame so the stream resynchronises.
// Optional colour-bar generator: define VGA_SCANOUT_TEST_PATTERN_EN.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [8:0] pix_data,
  input  logic       pix_sof,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [8:0] video,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       underflow,
  input  logic       test_en
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          active, first, vblank, hsync_win, vsync_win;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk      (clk),
    .reset_n  (reset_n),
    .hcnt_o   (hcnt),
    .vcnt_o   (vcnt),
    .active_o (active),
    .first_o  (first),
    .vblank_o (vblank),
    .hsync_o  (hsync_win),
    .vsync_o  (vsync_win)
  );

  // ---------------- pixel FIFO ----------------
  fifo_entry_t fifo_mem_q [FIFO_DEPTH];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q, count_d;
  logic        run_q;
  fifo_entry_t head;
  logic        empty, push, pop, starve;

  assign empty     = (count_q == 3'd0);
  assign head      = fifo_mem_q[rd_ptr_q];
  // run_q holds ready low until the first clock after reset release.
  assign pix_ready = run_q && (count_q != 3'(FIFO_DEPTH));
  assign push      = pix_valid && pix_ready;

  // Pop decision for the current raster position; starve marks a black pixel.
  always_comb begin
    pop    = 1'b0;
    starve = 1'b0;
    if (active) begin
      if (first) begin
        if (!empty && head.sof) pop = 1'b1;
        else                    starve = 1'b1;
      end else begin
        if (!empty && !head.sof) pop = 1'b1;
        else                     starve = 1'b1;
      end
    end else if (vblank) begin
      // Drop leftovers of an abandoned frame until the next frame start.
      pop = !empty && !head.sof;
    end
  end

  // Occupancy follows push/pop; both at once leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= '{sof: pix_sof, data: pix_data};
  end

  // FIFO pointers, occupancy and the post-reset ready enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      run_q   <= 1'b1;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
    end
  end

  // ---------------- output stage ----------------
  logic [8:0] video_q, video_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       blank_q, blank_d, underflow_q, underflow_d;
  logic       unused_cfg;

  // Next video/sync/blank/underflow for the current counter position.
  always_comb begin
    video_d     = (active && pop) ? head.data : 9'h000;
    underflow_d = starve;
    blank_d     = !active;
    hsync_d     = hsync_win ? HS_POL : !HS_POL;
    vsync_d     = vsync_win ? VS_POL : !VS_POL;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    if (test_en) begin
      underflow_d = 1'b0;
      if (active) video_d = BAR_COLORS[bar_index(32'(hcnt), H_ACTIVE / BAR_COUNT)];
    end
`endif
  end

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  assign unused_cfg = ^vcnt;
`else
  assign unused_cfg = ^{test_en, hcnt, vcnt};
`endif

  // Registered outputs, one cycle behind the counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      video_q     <= 9'h000;
      hsync_q     <= !HS_POL;
      vsync_q     <= !VS_POL;
      blank_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      video_q     <= video_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      blank_q     <= blank_d;
      underflow_q <= underflow_d;
    end
  end

  assign video     = video_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign blank     = blank_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed bench on a reduced 24x8 raster (16x4 visible,
// hsync at h 18..20, vsync on lines 5..6, 192-cycle frames).
module tb_vga_scanout;

  localparam int HT = 24;
  localparam int FR = 192;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [8:0] pix_data;
  logic       pix_sof, pix_valid, pix_ready;
  logic [8:0] video;
  logic       hsync, vsync, blank, underflow;
  logic       test_en;

  always #5 clk = ~clk;

  vga_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_data(pix_data), .pix_sof(pix_sof),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .video(video),
    .hsync(hsync), .vsync(vsync), .blank(blank), .underflow(underflow),
    .test_en(test_en)
  );

  int cyc = 0;
  int rel = 0;
  int n_vec = 0;
  int n_bad = 0;
  int src_mode = 0;
  int src_gen = 0;
  int stall_lo = 0;
  int stall_hi = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Stream source: mode 1 = index stream, sof every 64 pixels;
  // mode 2 = 100 stale pixels without sof, then sof-aligned frames.
  initial begin : source
    int idx, seen, n, j;
    bit will_push;
    idx = 0; seen = 0; will_push = 0;
    pix_valid = 0; pix_data = '0; pix_sof = 0;
    forever begin
      @(negedge clk);
      if (seen != src_gen) begin
        seen = src_gen; idx = 0; will_push = 0;
      end else if (will_push) begin
        idx++;
      end
      n = cyc - rel;
      pix_valid = (src_mode != 0) && !(n >= stall_lo && n < stall_hi);
      pix_sof = 1'b0;
      pix_data = '0;
      if (src_mode == 1) begin
        pix_data = 9'(idx);
        pix_sof  = (idx % 64 == 0);
      end else if (src_mode == 2) begin
        if (idx < 100) begin
          pix_data = 9'h100 | 9'(idx);
        end else begin
          j = idx - 100;
          pix_data = {3'b111, 6'(j)};
          pix_sof  = (j % 64 == 0);
        end
      end
      will_push = pix_valid && pix_ready;
    end
  end

  function automatic logic [12:0] ex(logic [8:0] vid, logic b, logic hs, logic vs, logic uf);
    return {vid, b, hs, vs, uf};
  endfunction

  function automatic logic [12:0] obs();
    return {video, blank, hsync, vsync, underflow};
  endfunction

  task automatic chk(input string name, input logic [12:0] got, input logic [12:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got video=%h blank=%b hs=%b vs=%b uf=%b, want video=%h blank=%b hs=%b vs=%b uf=%b",
               name, got[12:4], got[3], got[2], got[1], got[0],
               exp[12:4], exp[3], exp[2], exp[1], exp[0]);
    end else begin
      $display("ok   %s: video=%h blank=%b hs=%b vs=%b uf=%b",
               name, got[12:4], got[3], got[2], got[1], got[0]);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, got, exp);
    end else begin
      $display("ok   %s: %b", name, got);
    end
  endtask

  // Outputs for raster position (v,h) of frame f appear after clock f*FR+v*HT+h+1.
  task automatic check_at(input string name, input int f, input int v, input int h,
                          input logic [12:0] exp);
    int k;
    string nm;
    k = f * FR + v * HT + h + 1;
    nm = $sformatf("%s f%0d v%0d h%0d", name, f, v, h);
    if (cyc - rel > k) begin
      n_vec++; n_bad++;
      $display("FAIL %s: position already passed, got clock %0d want %0d", nm, cyc - rel, k);
    end else begin
      while (cyc - rel < k) @(negedge clk);
      chk(nm, obs(), exp);
    end
  endtask

  typedef struct {
    int f; int v; int h;
    logic [8:0] vid; logic b; logic hs; logic vs; logic uf;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic act, hs, vs, uf;
    logic [8:0] vid;
    //           f  v  h   video  bl hs vs uf
    vecs[0]  = '{0, 0, 0,  9'h000, 0, 1, 1, 1};
    vecs[1]  = '{0, 0, 1,  9'h000, 0, 1, 1, 1};
    vecs[2]  = '{0, 2, 7,  9'h000, 0, 1, 1, 1};
    vecs[3]  = '{0, 4, 3,  9'h000, 1, 1, 1, 0};
    vecs[4]  = '{1, 0, 0,  9'h000, 0, 1, 1, 0};
    vecs[5]  = '{1, 0, 1,  9'h001, 0, 1, 1, 0};
    vecs[6]  = '{1, 0, 15, 9'h00F, 0, 1, 1, 0};
    vecs[7]  = '{1, 0, 16, 9'h000, 1, 1, 1, 0};
    vecs[8]  = '{1, 0, 17, 9'h000, 1, 1, 1, 0};
    vecs[9]  = '{1, 0, 18, 9'h000, 1, 0, 1, 0};
    vecs[10] = '{1, 0, 20, 9'h000, 1, 0, 1, 0};
    vecs[11] = '{1, 0, 21, 9'h000, 1, 1, 1, 0};
    vecs[12] = '{1, 1, 0,  9'h010, 0, 1, 1, 0};
    vecs[13] = '{1, 3, 15, 9'h03F, 0, 1, 1, 0};
    vecs[14] = '{1, 4, 0,  9'h000, 1, 1, 1, 0};
    vecs[15] = '{1, 5, 0,  9'h000, 1, 1, 0, 0};
    vecs[16] = '{1, 5, 19, 9'h000, 1, 0, 0, 0};
    vecs[17] = '{1, 6, 23, 9'h000, 1, 1, 0, 0};
    vecs[18] = '{1, 7, 0,  9'h000, 1, 1, 1, 0};

    reset_n = 1'b0; test_en = 1'b0;
    src_mode = 1; src_gen = 1;
    repeat (3) @(negedge clk);
    chk("reset outputs", obs(), ex(9'h000, 1, 1, 1, 0));
    chk1("reset ready", pix_ready, 1'b0);
    reset_n = 1'b1; rel = cyc;
    #1;
    chk("release outputs", obs(), ex(9'h000, 1, 1, 1, 0));
    chk1("ready before first clock", pix_ready, 1'b0);
    @(negedge clk);
    chk1("ready after first clock", pix_ready, 1'b1);

    // Raster timing and streamed data, first frames after reset.
    for (int i = 0; i < NV; i++)
      check_at("vec", vecs[i].f, vecs[i].v, vecs[i].h,
               ex(vecs[i].vid, vecs[i].b, vecs[i].hs, vecs[i].vs, vecs[i].uf));

    // Whole of frame 2: pixel index stream, sync windows, blanking.
    for (int v = 0; v < 8; v++) begin
      for (int h = 0; h < HT; h++) begin
        act = (v < 4) && (h < 16);
        hs  = !(h >= 18 && h < 21);
        vs  = !(v >= 5 && v < 7);
        vid = act ? 9'(64 + v * 16 + h) : 9'h000;
        check_at("scan", 2, v, h, ex(vid, !act, hs, vs, 1'b0));
      end
    end

    // Stall the source for 10 clocks from frame 3 line 1 pixel 2.
    stall_lo = 3 * FR + HT + 2;
    stall_hi = stall_lo + 10;
    check_at("frame3 start", 3, 0, 0, ex(9'h080, 0, 1, 1, 0));
    for (int h = 0; h < 16; h++) begin
      uf  = (h >= 5 && h <= 12);
      vid = uf ? 9'h000 : ((h < 5) ? 9'(144 + h) : 9'(136 + h));
      check_at("stall", 3, 1, h, ex(vid, 0, 1, 1, uf));
    end
    check_at("after stall", 3, 2, 0, ex(9'h098, 0, 1, 1, 0));
    check_at("frame3 last", 3, 3, 15, ex(9'h0B7, 0, 1, 1, 0));
    check_at("resync", 4, 0, 0, ex(9'h0C0, 0, 1, 1, 0));
    check_at("resync", 4, 0, 1, ex(9'h0C1, 0, 1, 1, 0));

    // Mid-line asynchronous reset, then stale pixels followed by a real frame.
    @(posedge clk); #2;
    reset_n = 1'b0; stall_lo = 0; stall_hi = 0;
    src_mode = 2; src_gen = src_gen + 1;
    #1;
    chk("async reset outputs", obs(), ex(9'h000, 1, 1, 1, 0));
    chk1("async reset ready", pix_ready, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1; rel = cyc;
    #1;
    chk("mid release outputs", obs(), ex(9'h000, 1, 1, 1, 0));
    check_at("stale", 0, 0, 0, ex(9'h000, 0, 1, 1, 1));
    check_at("stale", 0, 0, 1, ex(9'h000, 0, 1, 1, 1));
    check_at("stale", 0, 0, 2, ex(9'h100, 0, 1, 1, 0));
    check_at("stale", 0, 0, 3, ex(9'h101, 0, 1, 1, 0));
    check_at("stale", 0, 3, 15, ex(9'h13D, 0, 1, 1, 0));
    check_at("stale", 0, 4, 0, ex(9'h000, 1, 1, 1, 0));
    check_at("sof frame", 1, 0, 0, ex(9'h1C0, 0, 1, 1, 0));
    check_at("sof frame", 1, 0, 1, ex(9'h1C1, 0, 1, 1, 0));
    check_at("sof frame", 1, 1, 0, ex(9'h1D0, 0, 1, 1, 0));

    // Colour bars with an empty stream.
    @(posedge clk); #2;
    reset_n = 1'b0; src_mode = 0; src_gen = src_gen + 1; test_en = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1; rel = cyc;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    check_at("bars", 0, 0, 0,  ex(9'h1FF, 0, 1, 1, 0));
    check_at("bars", 0, 0, 2,  ex(9'h1F8, 0, 1, 1, 0));
    check_at("bars", 0, 0, 5,  ex(9'h03F, 0, 1, 1, 0));
    check_at("bars", 0, 0, 15, ex(9'h000, 0, 1, 1, 0));
    check_at("bars", 0, 1, 8,  ex(9'h1C7, 0, 1, 1, 0));
`else
    check_at("bars off", 0, 0, 0,  ex(9'h000, 0, 1, 1, 1));
    check_at("bars off", 0, 0, 2,  ex(9'h000, 0, 1, 1, 1));
    check_at("bars off", 0, 0, 15, ex(9'h000, 0, 1, 1, 1));
`endif
    check_at("bars blank", 0, 0, 16, ex(9'h000, 1, 1, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
